instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 114 +++++++++++
 tb/tb_instruction_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction loader: streams a big-endian byte image into the MIPS instruction
// memory while holding the core in reset, then releases the core to run.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; core held in reset, waiting for load_start
// LOAD  | accepting bytes, assembling words, writing each completed word
// DRAIN | final word's write strobe is out; core still held in reset
// RUN   | core released; a new load_start may begin another session
module instruction_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [8:0]  word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  word_idx;
    logic [7:0]  last_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic        start_ok;
    logic        accept;
    logic        word_end;
    logic        final_word;

    // load_start is only honoured outside an active session
    assign start_ok   = load_start && ((state == IDLE) || (state == RUN));
    assign accept     = byte_valid && byte_ready;
    assign word_end   = accept && (byte_cnt == 2'd3);
    assign final_word = word_end && (word_idx == last_idx);

    assign byte_ready = (state == LOAD);
    assign busy       = (state == LOAD) || (state == DRAIN);
    assign cpu_rst    = (state != RUN);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode; an empty image skips straight to RUN
    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN: begin
                if (start_ok) begin
                    state_next = (word_count == 9'd0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (final_word) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // byte assembly, word index, registered write strobe and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx   <= 8'd0;
            last_idx   <= 8'd0;
            byte_cnt   <= 2'd0;
            partial    <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 8'd0;
            imem_wdata <= 32'd0;
            done       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= (state == DRAIN);
            if (start_ok) begin
                word_idx <= 8'd0;
                byte_cnt <= 2'd0;
                // counts above 256 are clamped to a full 256-word image
                last_idx <= (word_count >= 9'd256) ? 8'hFF : (word_count[7:0] - 8'd1);
                done     <= (word_count == 9'd0);
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (word_end) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_idx;
                    imem_wdata <= {partial, byte_data};
                    // the index stops at the last word so it never wraps
                    if (!final_word) begin
                        word_idx <= word_idx + 8'd1;
                    end
                end else begin
                    partial <= {partial[15:0], byte_data};
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed testbench for instruction_loader.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [8:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int         wr_cnt = 0;
    int         wr_base = 0;
    int         seq_err = 0;
    int         data_err = 0;
    logic [7:0] wr_last = 8'd0;
    logic       check_data = 1'b0;

    instruction_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {a, ~a, 8'hC3, a ^ 8'h5A};
    endfunction

    // write log: addresses must run 0,1,2,... within a session
    always @(negedge clk) begin
        if (imem_we) begin
            if (imem_addr != 8'(wr_cnt - wr_base)) seq_err++;
            if (check_data && (imem_wdata != pat(imem_addr))) data_err++;
            wr_last = imem_addr;
            wr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        byte_valid = 1'b0;
        repeat (gap) step();
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = byte_ready;
            step();
        end
        byte_valid = 1'b0;
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic start(input logic [8:0] wc);
        load_start = 1'b1;
        word_count = wc;
        step();
        load_start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        word_count = 9'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;

        // reset state
        step();
        step();
        chk("rst_cpu_rst",    32'(cpu_rst),    32'd1);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_imem_we",    32'(imem_we),    32'd0);
        chk("rst_imem_addr",  32'(imem_addr),  32'd0);
        chk("rst_imem_wdata", imem_wdata,      32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        rst = 1'b0;
        step();
        chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);

        // single-word load
        wr_base = wr_cnt;
        start(9'd1);
        chk("load_busy",       32'(busy),       32'd1);
        chk("load_byte_ready", 32'(byte_ready), 32'd1);
        chk("load_cpu_rst",    32'(cpu_rst),    32'd1);
        send_word(32'h8C040000, 0);
        chk("w1_we",         32'(imem_we),    32'd1);
        chk("w1_addr",       32'(imem_addr),  32'h00);
        chk("w1_data",       imem_wdata,      32'h8C040000);
        chk("drain_ready",   32'(byte_ready), 32'd0);
        chk("drain_cpu_rst", 32'(cpu_rst),    32'd1);
        chk("drain_busy",    32'(busy),       32'd1);
        chk("drain_done",    32'(done),       32'd0);
        step();
        chk("run_done",    32'(done),    32'd1);
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_busy",    32'(busy),    32'd0);
        chk("run_we",      32'(imem_we), 32'd0);
        step();
        chk("run_done_pulse", 32'(done), 32'd0);
        chk("w1_writes", 32'(wr_cnt - wr_base), 32'd1);

        // stalled stream, started with a byte offered alongside load_start
        wr_base    = wr_cnt;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        start(9'd2);
        byte_valid = 1'b0;
        chk("stall_cpu_rst", 32'(cpu_rst), 32'd1);
        send_word(32'h12345678, 3);
        chk("s0_we",   32'(imem_we),   32'd1);
        chk("s0_addr", 32'(imem_addr), 32'h00);
        chk("s0_data", imem_wdata,     32'h12345678);
        step();
        chk("s0_we_once", 32'(imem_we), 32'd0);
        send_word(32'h9ABCDEF0, 3);
        chk("s1_we",   32'(imem_we),   32'd1);
        chk("s1_addr", 32'(imem_addr), 32'h01);
        chk("s1_data", imem_wdata,     32'h9ABCDEF0);
        step();
        chk("s_done",   32'(done),              32'd1);
        chk("s_writes", 32'(wr_cnt - wr_base),  32'd2);
        chk("s_seq",    32'(seq_err),           32'd0);

        // load_start during LOAD is ignored
        wr_base = wr_cnt;
        start(9'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        load_start = 1'b1;
        word_count = 9'd5;
        step();
        load_start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        chk("ign_w0_addr", 32'(imem_addr), 32'h00);
        chk("ign_w0_data", imem_wdata,     32'h01020304);
        send_word(32'hCAFEF00D, 0);
        chk("ign_w1_addr", 32'(imem_addr), 32'h01);
        chk("ign_w1_busy", 32'(busy),      32'd1);
        step();
        chk("ign_done",   32'(done),             32'd1);
        chk("ign_writes", 32'(wr_cnt - wr_base), 32'd2);

        // word_count = 0 goes straight to RUN with a done pulse
        wr_base = wr_cnt;
        start(9'd0);
        chk("z_done",    32'(done),    32'd1);
        chk("z_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("z_busy",    32'(busy),    32'd0);
        step();
        chk("z_done_pulse", 32'(done), 32'd0);
        chk("z_writes", 32'(wr_cnt - wr_base), 32'd0);

        // full 256-word image, then a clamped 300-word request
        check_data = 1'b1;
        for (int run = 0; run < 2; run++) begin
            wr_base  = wr_cnt;
            data_err = 0;
            start((run == 0) ? 9'd256 : 9'd300);
            for (int i = 0; i < 256; i++) send_word(pat(8'(i)), 0);
            chk("full_last_we",   32'(imem_we),   32'd1);
            chk("full_last_addr", 32'(imem_addr), 32'hFF);
            chk("full_ready",     32'(byte_ready), 32'd0);
            step();
            chk("full_done",    32'(done),             32'd1);
            chk("full_cpu_rst", 32'(cpu_rst),          32'd0);
            chk("full_writes",  32'(wr_cnt - wr_base), 32'd256);
            chk("full_wr_last", 32'(wr_last),          32'hFF);
            chk("full_data",    32'(data_err),         32'd0);
        end
        check_data = 1'b0;
        chk("full_seq", 32'(seq_err), 32'd0);

        // reset after two bytes of the fourth word
        wr_base = wr_cnt;
        start(9'd4);
        send_word(32'h00000001, 0);
        send_word(32'h00000002, 0);
        send_word(32'h00000003, 0);
        send_byte(8'hEE, 0);
        send_byte(8'hDD, 0);
        rst = 1'b1;
        step();
        chk("mr_busy",    32'(busy),       32'd0);
        chk("mr_ready",   32'(byte_ready), 32'd0);
        chk("mr_cpu_rst", 32'(cpu_rst),    32'd1);
        chk("mr_addr",    32'(imem_addr),  32'd0);
        rst = 1'b0;
        step();
        chk("mr_no_we",  32'(imem_we),          32'd0);
        chk("mr_writes", 32'(wr_cnt - wr_base), 32'd3);
        wr_base = wr_cnt;
        start(9'd1);
        send_word(32'h11223344, 0);
        chk("mr_new_addr", 32'(imem_addr), 32'h00);
        chk("mr_new_data", imem_wdata,     32'h11223344);
        step();
        chk("mr_new_done", 32'(done), 32'd1);
        chk("mr_new_seq",  32'(seq_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
